// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for 7-segment bus monitoring.
//   - Segment bit order on a 7-bit segment bus: bit 6 = a ... bit 0 = g.
//   - Legal digit patterns SEG_0..SEG_9, plus the accepted alternates.
//   - State type of the capture FSM.
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Segment bit positions within a 7-bit segment word.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Primary digit patterns (active-high, a..g).
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    // Alternate renderings some drivers use.
    localparam logic [6:0] SEG_6_ALT = 7'h1F;  // 6 without the top bar
    localparam logic [6:0] SEG_7_ALT = 7'h72;  // 7 with the f segment lit
    localparam logic [6:0] SEG_9_ALT = 7'h73;  // 9 without the bottom bar

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // digit enables not one-hot
        ST_COUNT = 2'd1,  // one-hot pattern present, waiting for stability
        ST_HELD  = 2'd2   // pattern captured, holding until it changes
    } seg7_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// -----------------------------------------------------------------------------
// seg7_to_bcd
// Combinational decode of one 7-segment pattern into its BCD value.
// Ports:
//   seg   in  7  segment pattern, bit 6 = a ... bit 0 = g
//   legal out 1  pattern is a recognised digit (including alternates)
//   bcd   out 4  decoded value, 0 when the pattern is not legal
// -----------------------------------------------------------------------------
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0:                bcd = 4'd0;
            SEG_1:                bcd = 4'd1;
            SEG_2:                bcd = 4'd2;
            SEG_3:                bcd = 4'd3;
            SEG_4:                bcd = 4'd4;
            SEG_5:                bcd = 4'd5;
            SEG_6, SEG_6_ALT:     bcd = 4'd6;
            SEG_7, SEG_7_ALT:     bcd = 4'd7;
            SEG_8:                bcd = 4'd8;
            SEG_9, SEG_9_ALT:     bcd = 4'd9;
            default:              legal = 1'b0;  // blank and everything else
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
// Watches a multiplexed 7-segment drive bus and recovers the BCD value shown
// on each digit. A {segment, enable} pattern is captured once it has been
// present at STABLE_CYCLES consecutive rising edges.
// Ports:
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        synchronous active-low reset
//   seg_7      in   7        segment lines, bit 6 = a ... bit 0 = g
//   an         in   N_DIG    digit enables, meaningful only when one-hot
//   digits     out  4*N_DIG  captured BCD, digit i at [4i+3:4i]
//   dig_valid  out  N_DIG    digit i holds a legal captured value
//   frame_done out  1        pulse when every digit captured since last pulse
//   err        out  1        pulse when a stable pattern is not a legal digit
//   bad_pat    out  7        last illegal pattern, loaded with err
//   state      out  2        capture FSM state (observation only)
// Output semantics: there is no handshake; a capture is an event that updates
// digits/dig_valid (legal) or pulses err and loads bad_pat (illegal) at the
// capture edge. frame_done/err are single-cycle and never back-pressured.
// -----------------------------------------------------------------------------
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int N_DIG         = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_7,
    input  logic [N_DIG-1:0]     an,
    output logic [4*N_DIG-1:0]   digits,
    output logic [N_DIG-1:0]     dig_valid,
    output logic                 frame_done,
    output logic                 err,
    output logic [6:0]           bad_pat,
    output seg7_state_t          state
);

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]       s_seg;
    logic [N_DIG-1:0] s_an;
    logic [7:0]       stab_cnt;
    logic [N_DIG-1:0] seen;

    logic             an_onehot;
    logic             same;
    logic             strobe;
    logic             pat_legal;
    logic [3:0]       pat_bcd;
    logic [N_DIG-1:0] seen_next;

    seg7_to_bcd u_dec (
        .seg   (seg_7),
        .legal (pat_legal),
        .bcd   (pat_bcd)
    );

    always_comb begin
        an_onehot = $onehot(an);
        same      = (seg_7 == s_seg) && (an == s_an);
        // Fires on the STABLE_CYCLES-th edge of a hold; once stab_cnt
        // saturates past STAB_LAST it cannot fire again until the pins change.
        strobe    = an_onehot && same && (stab_cnt == STAB_LAST);
        seen_next = seen | an;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg      <= '0;
            s_an       <= '0;
            stab_cnt   <= '0;
            seen       <= '0;
            digits     <= '0;
            dig_valid  <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            bad_pat    <= '0;
            state      <= ST_IDLE;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;

            // Stability tracking.
            if (!same || !an_onehot) begin
                s_seg    <= seg_7;
                s_an     <= an;
                stab_cnt <= 8'd1;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end

            // Capture; an is one-hot here so it doubles as the digit mask.
            if (strobe) begin
                if (pat_legal) begin
                    for (int i = 0; i < N_DIG; i++) begin
                        if (an[i]) digits[4*i +: 4] <= pat_bcd;
                    end
                    dig_valid <= dig_valid | an;
                    if (seen_next == '1) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_next;
                    end
                end else begin
                    dig_valid <= dig_valid & ~an;
                    err       <= 1'b1;
                    bad_pat   <= seg_7;
                end
            end

            // FSM.
            if (!an_onehot) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:  state <= ST_COUNT;
                    ST_COUNT: state <= strobe ? ST_HELD : ST_COUNT;
                    ST_HELD:  state <= same ? ST_HELD : ST_COUNT;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
